// File: rtl/seg_scan_driver_if.sv
// Display register bundle presented to seg_scan_driver.
// Fields: load strobe, value nibbles, dots, digit_en, blink_en, lz_blank.
interface seg_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dots;
    logic [DIGITS-1:0]     digit_en;
    logic [DIGITS-1:0]     blink_en;
    logic                  lz_blank;

    modport master (
        output load,
        output value,
        output dots,
        output digit_en,
        output blink_en,
        output lz_blank
    );

    modport slave (
        input load,
        input value,
        input dots,
        input digit_en,
        input blink_en,
        input lz_blank
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver.
// Ports: clk, rst_n (async low), bus (slave: load/value/dots/digit_en/
//   blink_en/lz_blank), seg[7:0] (dp,g..a active low), an (active low),
//   frame_done (one-cycle pulse per scan wrap).
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_driver_if.slave   bus,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  an,
    output logic               frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PSC_LAST = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*DIGITS-1:0] value;
        logic [DIGITS-1:0]   dots;
        logic [DIGITS-1:0]   en;
        logic [DIGITS-1:0]   blink;
        logic                lz;
    } disp_t;

    disp_t             pend;
    disp_t             disp;
    logic              pend_valid;

    logic [PW-1:0]     psc;
    logic [IW-1:0]     idx;
    logic [FW-1:0]     frm;
    logic              phase;

    logic              slot_end;
    logic              wrap;

    logic [DIGITS-1:0] hot;
    logic [3:0]        nib;
    logic [DIGITS-1:0] lz_mask;
    logic              cur_dot;
    logic              cur_en;
    logic              cur_lz;
    logic              cur_blink;
    logic              blank;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        unique case (n)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            4'hF: f = 7'b0001110;
        endcase
        return f;
    endfunction

    assign slot_end = (psc == PSC_LAST);
    assign wrap     = slot_end && (idx == IDX_LAST);

    // Slot prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            idx <= '0;
        end else if (slot_end) begin
            psc <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            psc <= psc + 1'b1;
        end
    end

    // Blink phase advances once per BLINK_FRAMES completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            if (frm == FRM_LAST) begin
                frm   <= '0;
                phase <= ~phase;
            end else begin
                frm <= frm + 1'b1;
            end
        end
    end

    // Pending/display double buffer. The display copy only changes on
    // the wrap edge, so a frame never mixes old and new content; a load
    // on that same edge refills pending for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            disp       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (wrap && pend_valid) begin
                disp <= pend;
            end
            if (bus.load) begin
                pend.value <= bus.value;
                pend.dots  <= bus.dots;
                pend.en    <= bus.digit_en;
                pend.blink <= bus.blink_en;
                pend.lz    <= bus.lz_blank;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while nibbles are
    // zero and no dot has been seen; digit 0 is never masked.
    always_comb begin
        logic run;
        lz_mask = '0;
        run     = disp.lz;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run = run
                && (disp.value[4*i +: 4] == 4'h0)
                && !disp.dots[i];
            lz_mask[i] = run;
        end
    end

    // One-hot of the current index and its nibble.
    always_comb begin
        hot = '0;
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                hot[i] = 1'b1;
                nib    = disp.value[4*i +: 4];
            end
        end
    end

    assign cur_dot   = |(disp.dots & hot);
    assign cur_en    = |(disp.en & hot);
    assign cur_lz    = |(lz_mask & hot);
    assign cur_blink = |(disp.blink & hot);

    assign blank = !cur_en || cur_lz || (cur_blink && phase);

    // Registered outputs. The slot_end edge forces an all-dark cycle so
    // the outgoing digit's segments never overlap the next anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 8'hFF;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end || blank) begin
                seg <= 8'hFF;
                an  <= '1;
            end else begin
                seg <= {~cur_dot, font(nib)};
                an  <= ~hot;
            end
        end
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a bank of common-anode seven-segment digits, parametrised in digit count and scan rate.
- Holds a hex value per digit and scans one digit per slot, producing active-low segment and anode-select outputs.
- Features beyond a single-digit decoder: per-digit dots, per-digit enables, leading-zero blanking, per-digit blink, and tear-free updates committed only at frame boundaries.
- Sits between CPU-visible display registers and the board display pins.

Parameters:
- DIGITS, 8, number of digits (1..16).
- CLK_DIV, 1000, clock cycles per digit slot (>=2).
- BLINK_FRAMES, 64, scan frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; captures value, dots, digit_en, blink_en and lz_blank into the pending registers.
- value  in  4*DIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
- dots  in  DIGITS  dot request, one bit per digit.
- digit_en  in  DIGITS  per-digit enable; 0 = digit dark.
- blink_en  in  DIGITS  per-digit blink enable.
- lz_blank  in  1  leading-zero blanking enable.
- seg  out  8  active-low segments; bit 7 = dp, bits 6..0 = g..a.
- an  out  DIGITS  active-low anode select; at most one bit low.
- frame_done  out  1  one-cycle pulse on scan wrap.

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, display registers=0, pending registers=0, pending_valid=0, blink frame counter=0, blink phase=0, seg=8'hFF, an=all ones, frame_done=0.
- Prescaler counts 0..CLK_DIV-1. At terminal count it returns to 0 and the digit index advances.
- Digit index wraps DIGITS-1 -> 0. On that wrap, frame_done pulses for one cycle.
- Pending update: load copies the inputs into the pending registers and sets pending_valid.
  - A later load before commit overwrites the pending registers (last wins).
  - On the wrap cycle with pending_valid=1, pending copies into the display registers and pending_valid clears.
  - A load on the same cycle as a wrap is captured as pending and commits at the next wrap. The earlier pending content commits now.
- Blink: frame counter increments on each wrap. At BLINK_FRAMES-1 it clears and the blink phase toggles. A digit with blink_en=1 is blanked while phase=1.
- Leading-zero blank: when lz_blank=1, digit i (i>=1) is blanked if nibbles i..DIGITS-1 are all zero. Digit 0 is never LZ-blanked. A dot on a digit defeats LZ blanking for that digit and all digits below it.
- A digit is blanked if digit_en=0, or it is LZ-blanked, or it is blinked off. For a blanked digit: seg=8'hFF and an=all ones for that slot.
- A digit that is not blanked drives: an bit[index]=0, all other an bits=1, seg[7]=~dot, seg[6:0]=font(nibble).
- Font (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs are registered. seg and an reflect the digit index one cycle after the index changes, so the first lit slot appears in the cycle after reset release.
- Ghosting guard: on the cycle the index advances, the registered an is all ones for exactly one cycle. The new digit appears on the next cycle.
- Reset mid-frame: all state returns to reset values immediately. Pending data is lost.

Test Plan:
- DIGITS=4, CLK_DIV=4, load value=16'h12AF, digit_en=4'hF, dots=0. Required: display commits at the first wrap; an sequence 1110, 1101, 1011, 0111, each digit lit for 3 cycles plus a 1-cycle all-ones gap; seg 0001110, 0001000, 0100100, 1111001 with seg[7]=1; frame_done pulses every 16 cycles.
- Load value=16'h0005, lz_blank=1. Required: digits 3..1 dark (seg=FF, an=1111 in those slots), digit 0 shows 0010010. Then load dots=4'b0100: digits 2..0 lit with digit 2 seg=8'h40, digit 3 still dark.
- Blink: BLINK_FRAMES=2, blink_en=4'b0001. Required: digit 0 dark for 2 frames, then lit for 2 frames, then dark again; the other digits remain steady throughout.
- Tear-free update: load value=16'h1111, then mid-frame load 16'h2222 followed by 16'h3333. Required: the current frame still shows the old value; the next frame shows only 3333, with no 2222 ever driven.
- Load on the wrap cycle. Required: the previously pending data commits now; the new data commits at the following wrap.
- Assert rst_n low mid-scan. Required: the same cycle gives seg=FF, an=1111, frame_done=0; after release the scan restarts at digit 0 showing 0 only after a new load commits (display registers=0 with digit_en=0 means dark).
